flag_register_unit: RTL and testbench

// Producer side of the RFlag_ZCSO interface. Captures ALU status flags (Z, C, S, O),

---
 rtl/flag_pkg.sv | 26 ++
 rtl/flag_stack.sv | 81 ++++++++
 rtl/flag_register_unit.sv | 81 ++++++++
 tb/tb_flag_register_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared flag definitions: bit positions, the flag word type and the condition codes
// decoded by the conditional-jump flag tester.
package flag_pkg;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_S = 2;
  localparam int unsigned FLG_O = 3;

  typedef logic [3:0] flags_t;

  localparam logic [3:0] CC_TRUE  = 4'b0000;
  localparam logic [3:0] CC_O     = 4'b0011;
  localparam logic [3:0] CC_S     = 4'b0100;
  localparam logic [3:0] CC_Z     = 4'b0101;
  localparam logic [3:0] CC_C     = 4'b0110;
  localparam logic [3:0] CC_SZ    = 4'b0111;
  localparam logic [3:0] CC_FORCE = 4'b1100;
  localparam logic [3:0] CC_NEVER = 4'b1111;

  // Bitwise select: take nxt where wen is set, keep cur elsewhere.
  function automatic flags_t merge_flags(flags_t cur, flags_t nxt, flags_t wen);
    return (nxt & wen) | (cur & ~wen);
  endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of flag words for call/interrupt save/restore. Illegal operations (push when
// full, pop when empty, push and pop together) leave the stack untouched and set a sticky error.
module flag_stack
  import flag_pkg::*;
#(
  parameter int unsigned Depth  = 8,
  parameter int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  flags_t            din,
  output flags_t            top,
  output logic              pop_ok,
  output logic              empty,
  output logic              full,
  output logic [DepthW-1:0] depth,
  output logic              err
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DepthW-1:0] sp_q, sp_d;
  logic              err_q, err_d;
  logic              do_push, do_pop;
  logic [AddrW-1:0]  wr_idx, rd_idx;
  flags_t            mem_q [Depth];

  assign empty  = (sp_q == '0);
  assign full   = (sp_q == DepthW'(Depth));
  assign depth  = sp_q;
  assign err    = err_q;
  assign pop_ok = do_pop;

  assign wr_idx = AddrW'(sp_q);
  assign rd_idx = AddrW'(sp_q - DepthW'(1));
  assign top    = mem_q[rd_idx];

  always_comb begin
    sp_d    = sp_q;
    err_d   = err_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (push && pop) begin
      err_d = 1'b1;
    end else if (push) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        do_push = 1'b1;
        sp_d    = sp_q + DepthW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        do_pop = 1'b1;
        sp_d   = sp_q - DepthW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Contents are don't-care after reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/flag_register_unit.sv
// Architectural Z/C/S/O flag register with masked ALU update, zero-latency forward and,
// when FLAG_STACK_EN is defined, a save/restore stack.
module flag_register_unit
  import flag_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 8,
  parameter logic [3:0]  RST_FLAGS = 4'b0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     alu_zcso,
  input  logic                           alu_valid,
  input  logic [3:0]                     flag_wmask,
  input  logic                           flag_clr,
  input  logic                           flag_push,
  input  logic                           flag_pop,
  output logic [3:0]                     rflag_zcso,
  output logic [3:0]                     fwd_zcso,
  output logic                           stk_empty,
  output logic                           stk_full,
  output logic [$clog2(STK_DEPTH+1)-1:0] stk_depth,
  output logic                           stk_err
);

  flags_t flags_q, flags_d;
  flags_t alu_next;
  flags_t pop_data;
  logic   pop_ok;

  assign alu_next = merge_flags(flags_q, alu_zcso, flag_wmask & {4{alu_valid}});

`ifdef FLAG_STACK_EN
  flag_stack #(
    .Depth  (STK_DEPTH),
    .DepthW ($clog2(STK_DEPTH + 1))
  ) u_flag_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (flag_push),
    .pop    (flag_pop),
    .din    (flags_q),
    .top    (pop_data),
    .pop_ok (pop_ok),
    .empty  (stk_empty),
    .full   (stk_full),
    .depth  (stk_depth),
    .err    (stk_err)
  );
`else
  logic unused_stk_ctrl;
  assign unused_stk_ctrl = flag_push ^ flag_pop;
  assign pop_data  = '0;
  assign pop_ok    = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_full  = 1'b0;
  assign stk_depth = '0;
  assign stk_err   = 1'b0;
`endif

  // A legal pop still consumes its entry when flag_clr wins the register.
  always_comb begin
    flags_d = alu_next;
    if (flag_clr) begin
      flags_d = RST_FLAGS;
    end else if (pop_ok) begin
      flags_d = pop_data;
    end
  end

  assign fwd_zcso   = flags_d;
  assign rflag_zcso = flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= RST_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_flag_register_unit.sv
// Self-checking bench for flag_register_unit: constant vector table, hand-written stack
// sequences and randomized traffic against a queue-based reference model.
module tb_flag_register_unit;

  localparam int unsigned STK_DEPTH = 8;
  localparam logic [3:0]  RST_FLAGS = 4'b0000;
  localparam int unsigned DW        = $clog2(STK_DEPTH + 1);
`ifdef FLAG_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    alu_zcso;
  logic          alu_valid;
  logic [3:0]    flag_wmask;
  logic          flag_clr;
  logic          flag_push;
  logic          flag_pop;
  logic [3:0]    rflag_zcso;
  logic [3:0]    fwd_zcso;
  logic          stk_empty;
  logic          stk_full;
  logic [DW-1:0] stk_depth;
  logic          stk_err;

  flag_register_unit #(
    .STK_DEPTH (STK_DEPTH),
    .RST_FLAGS (RST_FLAGS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_zcso   (alu_zcso),
    .alu_valid  (alu_valid),
    .flag_wmask (flag_wmask),
    .flag_clr   (flag_clr),
    .flag_push  (flag_push),
    .flag_pop   (flag_pop),
    .rflag_zcso (rflag_zcso),
    .fwd_zcso   (fwd_zcso),
    .stk_empty  (stk_empty),
    .stk_full   (stk_full),
    .stk_depth  (stk_depth),
    .stk_err    (stk_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  bit         m_err;
  logic [3:0] last_fwd;

  typedef struct {
    bit         v;
    logic [3:0] z;
    logic [3:0] m;
    bit         c;
    logic [3:0] exp_fwd;
    logic [3:0] exp_flags;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_next(bit v, logic [3:0] z, logic [3:0] m, bit c,
                                            bit pu, bit po);
    logic [3:0] n;
    if (c) return RST_FLAGS;
    if (STK_EN && po && !pu && m_stk.size() > 0) return m_stk[$];
    for (int i = 0; i < 4; i++) n[i] = (v && m[i]) ? z[i] : m_flags[i];
    return n;
  endfunction

  task automatic check_state();
    chk("rflag", 32'(rflag_zcso), 32'(m_flags));
    chk("stk_depth", 32'(stk_depth), 32'(m_stk.size()));
    chk("stk_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
    chk("stk_full", 32'(stk_full), 32'(m_stk.size() == STK_DEPTH));
    chk("stk_err", 32'(stk_err), 32'(m_err));
  endtask

  // Applies one cycle of inputs just after a rising edge, checks forward, then state.
  task automatic step(bit r, bit v, logic [3:0] z, logic [3:0] m, bit c, bit pu, bit po);
    logic [3:0] exp_n;
    rst = r; alu_valid = v; alu_zcso = z; flag_wmask = m;
    flag_clr = c; flag_push = pu; flag_pop = po;
    #1;
    exp_n    = model_next(v, z, m, c, pu, po);
    last_fwd = fwd_zcso;
    if (!r) chk("fwd", 32'(fwd_zcso), 32'(exp_n));
    @(posedge clk);
    if (r) begin
      m_flags = RST_FLAGS;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      if (STK_EN) begin
        if (pu && po) m_err = 1'b1;
        else if (pu) begin
          if (m_stk.size() == STK_DEPTH) m_err = 1'b1;
          else m_stk.push_back(m_flags);
        end else if (po) begin
          if (m_stk.size() == 0) m_err = 1'b1;
          else void'(m_stk.pop_back());
        end
      end
      m_flags = exp_n;
    end
    #1;
    check_state();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{v: 1, z: 4'b1111, m: 4'b0101, c: 0, exp_fwd: 4'b0101, exp_flags: 4'b0101};
    vecs[1] = '{v: 0, z: 4'b1111, m: 4'b1111, c: 0, exp_fwd: 4'b0101, exp_flags: 4'b0101};
    vecs[2] = '{v: 1, z: 4'b0010, m: 4'b0011, c: 0, exp_fwd: 4'b0110, exp_flags: 4'b0110};
    vecs[3] = '{v: 1, z: 4'b1111, m: 4'b1111, c: 1, exp_fwd: 4'b0000, exp_flags: 4'b0000};
    vecs[4] = '{v: 1, z: 4'b1010, m: 4'b1111, c: 0, exp_fwd: 4'b1010, exp_flags: 4'b1010};
    vecs[5] = '{v: 1, z: 4'b0101, m: 4'b1000, c: 0, exp_fwd: 4'b0010, exp_flags: 4'b0010};

    rst = 1'b1; alu_valid = 0; alu_zcso = 0; flag_wmask = 0;
    flag_clr = 0; flag_push = 0; flag_pop = 0;
    m_flags = RST_FLAGS; m_err = 0;
    @(posedge clk);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_flags", 32'(rflag_zcso), 32'(4'b0000));
    chk("reset_empty", 32'(stk_empty), 32'(1));
    chk("reset_depth", 32'(stk_depth), 32'(0));
    chk("reset_err", 32'(stk_err), 32'(0));

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].v, vecs[i].z, vecs[i].m, vecs[i].c, 1'b0, 1'b0);
      chk($sformatf("vec%0d_fwd", i), 32'(last_fwd), 32'(vecs[i].exp_fwd));
      chk($sformatf("vec%0d_flags", i), 32'(rflag_zcso), 32'(vecs[i].exp_flags));
    end

    if (STK_EN) begin
      // Push during an ALU write: stack keeps old flags, register takes new.
      step(1'b0, 1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'b1100, 4'b1111, 1'b0, 1'b1, 1'b0);
      chk("push_new_flags", 32'(rflag_zcso), 32'(4'b1100));
      chk("push_depth", 32'(stk_depth), 32'(1));
      step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("pop_restore", 32'(rflag_zcso), 32'(4'b0011));
      chk("pop_empty", 32'(stk_empty), 32'(1));

      // Pop beats a same-cycle ALU write.
      step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1);
      chk("pop_wins_fwd", 32'(last_fwd), 32'(4'b0011));
      // Clear with pop: entry consumed, register cleared.
      step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
      chk("clr_pop_flags", 32'(rflag_zcso), 32'(4'b0000));
      chk("clr_pop_depth", 32'(stk_depth), 32'(0));
      step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
      chk("pushpop_depth", 32'(stk_depth), 32'(0));
      chk("pushpop_err", 32'(stk_err), 32'(1));

      // Fill past capacity, then drain past empty.
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) begin
        step(1'b0, 1'b1, 4'(k + 1), 4'b1111, 1'b0, 1'b1, 1'b0);
        if (k == 7) chk("full_after_8", 32'(stk_full), 32'(1));
      end
      chk("overflow_err", 32'(stk_err), 32'(1));
      chk("overflow_depth", 32'(stk_depth), 32'(8));
      for (int k = 0; k < 8; k++) begin
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk($sformatf("lifo_%0d", k), 32'(rflag_zcso), 32'(7 - k));
      end
      step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("underflow_hold", 32'(rflag_zcso), 32'(0));
      idle();
      chk("err_sticky", 32'(stk_err), 32'(1));
    end else begin
      step(1'b0, 1'b1, 4'b1001, 4'b1111, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, k[0], ~k[0]);
        chk($sformatf("nostk_hold_%0d", k), 32'(rflag_zcso), 32'(4'b1001));
      end
      step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
      chk("nostk_err", 32'(stk_err), 32'(0));
      chk("nostk_empty", 32'(stk_empty), 32'(1));
    end

    // Reset asserted mid-sequence.
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
    chk("midrst_flags", 32'(rflag_zcso), 32'(RST_FLAGS));
    chk("midrst_depth", 32'(stk_depth), 32'(0));
    chk("midrst_err", 32'(stk_err), 32'(0));

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, 4'($urandom),
           4'($urandom), $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 28);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
